// File: rtl/spi_peripheral_rx.sv
// SPI mode-0 peripheral receiver with oversampled inputs.
// Frames arrive MSB first; a status word is shifted back on spi_miso.
module spi_peripheral_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [SYNC_STAGES:0]   sclk_s;
  logic [SYNC_STAGES:0]   cs_s;
  logic [SYNC_STAGES-1:0] mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_rise;
  logic                   cs_fall;
  logic                   mosi_sync;
  logic                   done;
  logic                   hs;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_W-1:0]      rx_shift;
  logic [DATA_W-1:0]      tx_shift;
  logic [DATA_W-1:0]      rx_word;

  assign sclk_rise = sclk_s[SYNC_STAGES-1] & ~sclk_s[SYNC_STAGES];
  assign sclk_fall = ~sclk_s[SYNC_STAGES-1] & sclk_s[SYNC_STAGES];
  assign cs_rise   = cs_s[SYNC_STAGES-1] & ~cs_s[SYNC_STAGES];
  assign cs_fall   = ~cs_s[SYNC_STAGES-1] & cs_s[SYNC_STAGES];
  assign busy      = ~cs_s[SYNC_STAGES-1];
  assign mosi_sync = mosi_s[SYNC_STAGES-1];
  assign rx_word   = {rx_shift[DATA_W-2:0], mosi_sync};
  assign done      = busy & sclk_rise & (bit_cnt == LAST);
  assign hs        = rx_valid & rx_ready;
  assign spi_miso  = spi_miso_oe & tx_shift[DATA_W-1];

  // Synchronizer chains; idle values avoid a false edge out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= '0;
      cs_s   <= '1;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-1:0], spi_clk};
      cs_s   <= {cs_s[SYNC_STAGES-1:0], spi_cs};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  // Bit counter, shift registers and chip-select bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      spi_miso_oe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (cs_rise) begin
        frame_err   <= (bit_cnt != '0);
        bit_cnt     <= '0;
        spi_miso_oe <= 1'b0;
      end else if (cs_fall) begin
        bit_cnt     <= '0;
        tx_shift    <= tx_data;
        spi_miso_oe <= 1'b1;
      end else if (busy) begin
        if (sclk_rise) begin
          rx_shift <= rx_word;
          if (bit_cnt == LAST) begin
            bit_cnt  <= '0;
            tx_shift <= tx_data;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else if (sclk_fall && bit_cnt != '0) begin
          // the fall right after a reload must keep the new MSB
          tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  // Output word, valid/ready handshake and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (hs) begin
        overrun <= 1'b0;
      end
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (hs) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_peripheral_rx.sv
// Bench for spi_peripheral_rx: directed table, corner sequences,
// and randomized frames against a frame-level reference model.
module tb_spi_peripheral_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int ferr_cnt = 0;
  logic [7:0] acc_q[$];

  spi_peripheral_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_clk(spi_clk), .spi_cs(spi_cs),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe), .tx_data(tx_data),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .overrun(overrun),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && rx_valid && rx_ready) acc_q.push_back(rx_data);
    if (frame_err) ferr_cnt++;
  end

  typedef struct {
    logic [7:0] word;
    logic [7:0] tx;
    bit         ready;
    bit         pulse;
    int         nbits;
    logic [7:0] e_data;
    bit         e_valid;
    bit         e_ovr;
    logic [7:0] e_miso;
    int         e_ferr;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    ticks(6);
  endtask

  task automatic cs_high();
    ticks(4);
    spi_cs = 1'b1;
    ticks(6);
  endtask

  task automatic send(input logic [7:0] w, input int n,
                      output logic [7:0] m);
    m = '0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = w[7-i];
      ticks(4);
      m[7-i] = spi_miso;
      spi_clk = 1'b1;
      ticks(4);
      spi_clk = 1'b0;
    end
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    ticks(1);
    rx_ready = 1'b0;
    ticks(1);
  endtask

  initial begin
    logic [7:0] m, m2, w, t;
    logic [7:0] md;
    bit         mv, mo, rdy, ab;
    int         nb, f0, exp_ferr;
    logic [7:0] exp_acc[$];

    tbl[0] = '{8'hA5, 8'h3C, 1'b0, 1'b0, 8, 8'hA5, 1'b1, 1'b0, 8'h3C, 0};
    tbl[1] = '{8'h11, 8'h00, 1'b0, 1'b1, 8, 8'h11, 1'b1, 1'b0, 8'h00, 0};
    tbl[2] = '{8'h22, 8'hFF, 1'b0, 1'b0, 8, 8'h11, 1'b1, 1'b1, 8'hFF, 0};
    tbl[3] = '{8'hC0, 8'h00, 1'b0, 1'b1, 5, 8'h11, 1'b0, 1'b0, 8'h00, 1};
    tbl[4] = '{8'hFF, 8'h81, 1'b0, 1'b0, 8, 8'hFF, 1'b1, 1'b0, 8'h81, 0};
    tbl[5] = '{8'h5A, 8'h96, 1'b1, 1'b1, 8, 8'h5A, 1'b0, 1'b0, 8'h96, 0};

    rst_n = 1'b0;
    spi_clk = 1'b0;
    spi_cs = 1'b1;
    spi_mosi = 1'b0;
    rx_ready = 1'b0;
    tx_data = 8'h00;
    ticks(3);
    rst_n = 1'b1;
    ticks(3);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_oe", 32'(spi_miso_oe), 32'd0);
    chk("rst_miso", 32'(spi_miso), 32'd0);

    for (int r = 0; r < 6; r++) begin
      if (tbl[r].pulse) pulse_ready();
      tx_data = tbl[r].tx;
      rx_ready = tbl[r].ready;
      f0 = ferr_cnt;
      cs_low();
      chk($sformatf("r%0d_busy", r), 32'(busy), 32'd1);
      send(tbl[r].word, tbl[r].nbits, m);
      cs_high();
      rx_ready = 1'b0;
      ticks(1);
      chk($sformatf("r%0d_data", r), 32'(rx_data), 32'(tbl[r].e_data));
      chk($sformatf("r%0d_valid", r), 32'(rx_valid), 32'(tbl[r].e_valid));
      chk($sformatf("r%0d_ovr", r), 32'(overrun), 32'(tbl[r].e_ovr));
      chk($sformatf("r%0d_ferr", r), 32'(ferr_cnt - f0), 32'(tbl[r].e_ferr));
      if (tbl[r].nbits == 8)
        chk($sformatf("r%0d_miso", r), 32'(m), 32'(tbl[r].e_miso));
    end
    chk("idle_miso", 32'(spi_miso), 32'd0);
    chk("idle_oe", 32'(spi_miso_oe), 32'd0);

    acc_q.delete();
    tx_data = 8'h55;
    rx_ready = 1'b1;
    cs_low();
    tx_data = 8'hAA;
    send(8'h12, 8, m);
    send(8'h34, 8, m2);
    cs_high();
    rx_ready = 1'b0;
    ticks(1);
    chk("b2b_count", 32'(acc_q.size()), 32'd2);
    chk("b2b_d0", (acc_q.size() > 0) ? 32'(acc_q[0]) : 32'hDEAD, 32'h12);
    chk("b2b_d1", (acc_q.size() > 1) ? 32'(acc_q[1]) : 32'hDEAD, 32'h34);
    chk("b2b_miso0", 32'(m), 32'h55);
    chk("b2b_miso1", 32'(m2), 32'hAA);
    chk("b2b_valid", 32'(rx_valid), 32'd0);

    tx_data = 8'hF0;
    cs_low();
    send(8'hC3, 3, m);
    rst_n = 1'b0;
    #2;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_oe", 32'(spi_miso_oe), 32'd0);
    chk("arst_miso", 32'(spi_miso), 32'd0);
    chk("arst_valid", 32'(rx_valid), 32'd0);
    chk("arst_ovr", 32'(overrun), 32'd0);
    spi_cs = 1'b1;
    ticks(2);
    rst_n = 1'b1;
    ticks(4);
    cs_low();
    send(8'h5A, 8, m);
    cs_high();
    ticks(1);
    chk("arst_data", 32'(rx_data), 32'h5A);
    chk("arst_valid2", 32'(rx_valid), 32'd1);
    chk("arst_miso2", 32'(m), 32'hF0);

    md = 8'h5A;
    mv = 1'b1;
    mo = 1'b0;
    exp_ferr = ferr_cnt;
    acc_q.delete();
    for (int k = 0; k < 24; k++) begin
      w = 8'($urandom);
      t = 8'($urandom);
      rdy = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 4) == 0);
      nb = ab ? int'($urandom_range(1, 7)) : 8;
      if (mv && $urandom_range(0, 1) == 1) begin
        pulse_ready();
        exp_acc.push_back(md);
        mv = 1'b0;
        mo = 1'b0;
      end
      if (rdy && mv) begin
        exp_acc.push_back(md);
        mv = 1'b0;
        mo = 1'b0;
      end
      tx_data = t;
      rx_ready = rdy;
      cs_low();
      send(w, nb, m);
      cs_high();
      rx_ready = 1'b0;
      ticks(1);
      if (ab) begin
        exp_ferr++;
      end else if (rdy) begin
        exp_acc.push_back(w);
        md = w;
        mv = 1'b0;
        mo = 1'b0;
      end else if (!mv) begin
        md = w;
        mv = 1'b1;
      end else begin
        mo = 1'b1;
      end
      chk($sformatf("rnd%0d_valid", k), 32'(rx_valid), 32'(mv));
      chk($sformatf("rnd%0d_data", k), 32'(rx_data), 32'(md));
      chk($sformatf("rnd%0d_ovr", k), 32'(overrun), 32'(mo));
      chk($sformatf("rnd%0d_ferr", k), 32'(ferr_cnt), 32'(exp_ferr));
      if (!ab) chk($sformatf("rnd%0d_miso", k), 32'(m), 32'(t));
    end
    chk("rnd_acc_count", 32'(acc_q.size()), 32'(exp_acc.size()));
    for (int i = 0; i < exp_acc.size(); i++)
      chk($sformatf("rnd_acc%0d", i),
          (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hDEAD, 32'(exp_acc[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
